// File: rtl/mdu_div.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient for LO, remainder for HI.
// Fixed 33-cycle latency from accept to the done pulse; abort and rst cancel without done.
module mdu_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_sh_q;
    logic [WIDTH-1:0] div_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dbz_pend_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic [WIDTH:0]   shift_r_d;
    logic             trial_ge_d;
    logic [WIDTH-1:0] trial_d;

    always_comb begin
        a_mag_d    = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag_d    = (is_signed && b[WIDTH-1]) ? -b : b;
        shift_r_d  = {rem_q, quo_sh_q[WIDTH-1]};
        // The restored remainder is always below the divisor, so the low WIDTH
        // bits of the difference are exact whenever the trial is non-negative.
        trial_ge_d = (shift_r_d >= {1'b0, div_q});
        trial_d    = shift_r_d[WIDTH-1:0] - div_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_sh_q    <= '0;
            div_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q  <= S_CALC;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        rem_q    <= '0;
                        div_q    <= b_mag_d;
                        // Divide-by-zero keeps the raw dividend so the remainder comes out unnegated.
                        if (b == '0) begin
                            dbz_pend_q <= 1'b1;
                            quo_sh_q   <= a;
                            neg_quo_q  <= 1'b0;
                            neg_rem_q  <= 1'b0;
                        end else begin
                            dbz_pend_q <= 1'b0;
                            quo_sh_q   <= a_mag_d;
                            neg_quo_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_q  <= is_signed & a[WIDTH-1];
                        end
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        if (trial_ge_d) begin
                            rem_q    <= trial_d;
                            quo_sh_q <= {quo_sh_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_q    <= shift_r_d[WIDTH-1:0];
                            quo_sh_q <= {quo_sh_q[WIDTH-2:0], 1'b0};
                        end
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (!abort) begin
                        done_q      <= 1'b1;
                        dbz_q       <= dbz_pend_q;
                        quotient_q  <= dbz_pend_q ? '1 : (neg_quo_q ? -quo_sh_q : quo_sh_q);
                        remainder_q <= neg_rem_q ? -rem_q : rem_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_div.sv
// Bench for mdu_div: random and directed divisions against an arithmetic reference,
// with a scoreboard monitor that also checks the 33-cycle done latency.
module tb_mdu_div;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;
    logic [1:0]   dbg_state;

    mdu_div #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .abort(abort), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .dbz(dbz),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: {dbz, quotient, remainder}
    logic [2*W:0] exp_q[$];
    int           due_q[$];
    logic [2*W:0] last_res = '0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // reference: plain arithmetic from the instruction semantics
    function automatic logic [2*W:0] model(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W-1:0] qs;
        logic signed [W-1:0] rs;
        if (y == 0) return {1'b1, 32'hFFFF_FFFF, x};
        if (!sgn) return {1'b0, x / y, x % y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'h0};
        qs = $signed(x) / $signed(y);
        rs = $signed(x) % $signed(y);
        return {1'b0, qs, rs};
    endfunction

    // monitor: pops and compares whenever done is presented
    always @(posedge clk) begin
        logic [2*W:0] e;
        int           d;
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                chk("quotient", quotient, e[2*W-1:W]);
                chk("remainder", remainder, e[W-1:0]);
                chk("dbz", {31'b0, dbz}, {31'b0, e[2*W]});
                chk("busy_at_done", {31'b0, busy}, 32'd0);
                chk("latency", cyc, d);
                last_res = e;
            end
        end
    end

    // driver tasks
    task automatic issue(input logic sgn, input logic [W-1:0] aa, input logic [W-1:0] bb, input bit push);
        @(negedge clk);
        start = 1'b1;
        is_signed = sgn;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
        if (push) begin
            exp_q.push_back(model(sgn, aa, bb));
            due_q.push_back(cyc + 33);
        end
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        start = 1'b0;
        is_signed = 1'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done within 60 cycles, expected done (cycle %0d)", cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_dbz"}, {31'b0, dbz}, 32'd0);
        chk({tag, "_quotient"}, quotient, 32'd0);
        chk({tag, "_remainder"}, remainder, 32'd0);
        chk({tag, "_state"}, {30'b0, dbg_state}, 32'd0);
    endtask

    typedef struct packed {
        logic         sgn;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } op_t;

    op_t dir_ops[6];

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rs;
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // directed operands, including overflow, all-ones and divide-by-zero
        dir_ops[0] = '{1'b0, 32'd100, 32'd7};
        dir_ops[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2};
        dir_ops[2] = '{1'b1, 32'd7, 32'hFFFF_FFFE};
        dir_ops[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF};
        dir_ops[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1};
        dir_ops[5] = '{1'b0, 32'h1234_5678, 32'd0};
        for (int i = 0; i < 6; i++) begin
            issue(dir_ops[i].sgn, dir_ops[i].x, dir_ops[i].y, 1);
            wait_done();
        end
        // dbz must drop the cycle after done
        @(posedge clk);
        #1;
        chk("dbz_clear", {31'b0, dbz}, 32'd0);
        chk("done_clear", {31'b0, done}, 32'd0);

        // start while busy (sampled at T10) is ignored
        issue(1'b0, 32'd1000, 32'd10, 1);
        repeat (10) @(negedge clk);
        start = 1'b1;
        a = 32'd77;
        b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // start in the done cycle is accepted; latency checked by monitor
        issue(1'b1, 32'hFFFF_FF00, 32'd9, 1);
        wait_done();
        issue(1'b0, 32'hDEAD_BEEF, 32'd3, 1);
        wait_done();

        // abort mid-CALC: no done, outputs hold previous result
        issue(1'b0, 32'd5555, 32'd11, 0);
        repeat (16) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_hold_quotient", quotient, last_res[2*W-1:W]);
        chk("abort_hold_remainder", remainder, last_res[W-1:0]);

        // abort with start in IDLE drops the request
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        a = 32'd9;
        b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_idle_busy", {31'b0, busy}, 32'd0);

        // asynchronous reset mid-CALC
        issue(1'b1, 32'h8765_4321, 32'd13, 0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'd123456, 32'd789, 1);
        wait_done();

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom);
            rx = $urandom;
            case ($urandom_range(0, 3))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 20));
                2: ry = -32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            issue(rs, rx, ry, 1);
            wait_done();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
